// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// mem_lsu_pkg : LSU op encodings, state encoding and op-decode helpers
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

  localparam int                  REG_ADDR_LEN = 5;
  localparam int                  REG_LEN      = 32;
  localparam logic [REG_LEN-1:0]  ZERO_WORD    = '0;
  localparam logic                RESET_ENABLE = 1'b1;
  localparam logic                WRITE_ENABLE = 1'b1;

  localparam logic [3:0] LSU_NONE = 4'd0;
  localparam logic [3:0] LSU_LB   = 4'd1;
  localparam logic [3:0] LSU_LH   = 4'd2;
  localparam logic [3:0] LSU_LW   = 4'd3;
  localparam logic [3:0] LSU_LBU  = 4'd4;
  localparam logic [3:0] LSU_LHU  = 4'd5;
  localparam logic [3:0] LSU_SB   = 4'd6;
  localparam logic [3:0] LSU_SH   = 4'd7;
  localparam logic [3:0] LSU_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } lsu_state_t;

  // Bytes moved by an op; 0 for NONE and for unused codes.
  function automatic logic [2:0] lsu_bytes(input logic [3:0] op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: lsu_bytes = 3'd1;
      LSU_LH, LSU_LHU, LSU_SH: lsu_bytes = 3'd2;
      LSU_LW, LSU_SW:          lsu_bytes = 3'd4;
      default:                 lsu_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic lsu_is_load(input logic [3:0] op);
    lsu_is_load = (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
                  (op == LSU_LBU) || (op == LSU_LHU);
  endfunction

  function automatic logic lsu_is_store(input logic [3:0] op);
    lsu_is_store = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_extend.sv
// ============================================================================
// lsu_extend : sign/zero extension of assembled little-endian load bytes
// Revision   : 1.0
// ============================================================================
`default_nettype none

module lsu_extend
  import mem_lsu_pkg::*;
(
  input  logic [3:0]          op,
  input  logic [REG_LEN-1:0]  data_in,
  output logic [REG_LEN-1:0]  data_out
);

  always_comb begin
    data_out = data_in;
    case (op)
      LSU_LB:  data_out = {{24{data_in[7]}}, data_in[7:0]};
      LSU_LH:  data_out = {{16{data_in[15]}}, data_in[15:0]};
      LSU_LBU: data_out = {24'h000000, data_in[7:0]};
      LSU_LHU: data_out = {16'h0000, data_in[15:0]};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// mem_lsu : byte-serial memory-stage load/store unit with pipeline stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_op,
  input  logic                     in_rd_we,
  input  logic [REG_ADDR_LEN-1:0]  in_rd,
  input  logic [DATA_W-1:0]        in_alu,
  input  logic [DATA_W-1:0]        in_sdata,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  output logic [7:0]               mem_dout,
  input  logic [7:0]               mem_din,
  output logic                     stall_req,
  output logic                     wb_we,
  output logic [REG_ADDR_LEN-1:0]  wb_addr,
  output logic [DATA_W-1:0]        wb_data
);

  lsu_state_t               state_q, state_d;
  logic [3:0]               op_q, op_d;
  logic                     rd_we_q, rd_we_d;
  logic [REG_ADDR_LEN-1:0]  rd_q, rd_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [DATA_W-1:0]        sdata_q, sdata_d;
  logic [2:0]               issue_q, issue_d;
  logic [2:0]               cap_q, cap_d;
  logic [REG_LEN-1:0]       bytes_q, bytes_d;
  logic                     wb_we_q, wb_we_d;
  logic [REG_ADDR_LEN-1:0]  wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]        wb_data_q, wb_data_d;

  logic                     in_reset;
  logic [2:0]               n_bytes;
  logic                     issuing, last_issue, capturing, last_cap, accept_mem;
  logic [REG_LEN-1:0]       assembled, extended;

  assign in_reset   = (rst == RESET_ENABLE);
  assign n_bytes    = lsu_bytes(op_q);
  assign issuing    = (state_q != ST_IDLE) && (issue_q < n_bytes);
  assign last_issue = issuing && (issue_q == n_bytes - 3'd1);
  // A byte requested last cycle is on mem_din now.
  assign capturing  = (state_q == ST_LOAD) && (cap_q < issue_q);
  assign last_cap   = capturing && (cap_q == n_bytes - 3'd1);
  assign accept_mem = (state_q == ST_IDLE) && in_valid &&
                      (lsu_is_load(in_op) || lsu_is_store(in_op));

  always_comb begin
    assembled = bytes_q;
    assembled[{cap_q[1:0], 3'b000} +: 8] = mem_din;
  end

  lsu_extend u_extend (
    .op       (op_q),
    .data_in  (assembled),
    .data_out (extended)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_we_d   = rd_we_q;
    rd_d      = rd_q;
    base_d    = base_q;
    sdata_d   = sdata_q;
    issue_d   = issue_q;
    cap_d     = cap_q;
    bytes_d   = bytes_q;
    wb_we_d   = wb_we_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE: begin
        wb_we_d = 1'b0;
        if (accept_mem) begin
          op_d    = in_op;
          rd_we_d = in_rd_we;
          rd_d    = in_rd;
          base_d  = in_alu[ADDR_W-1:0];
          sdata_d = in_sdata;
          issue_d = 3'd0;
          cap_d   = 3'd0;
          bytes_d = ZERO_WORD;
          state_d = lsu_is_load(in_op) ? ST_LOAD : ST_STORE;
        end else if (in_valid) begin
          wb_we_d   = (in_rd_we == WRITE_ENABLE) && (in_rd != '0);
          wb_addr_d = in_rd;
          wb_data_d = in_alu;
        end
      end
      ST_LOAD: begin
        if (issuing) issue_d = issue_q + 3'd1;
        if (capturing) begin
          bytes_d = assembled;
          cap_d   = cap_q + 3'd1;
        end
        if (last_cap) begin
          wb_we_d   = (rd_we_q == WRITE_ENABLE) && (rd_q != '0);
          wb_addr_d = rd_q;
          wb_data_d = extended;
          state_d   = ST_IDLE;
        end
      end
      ST_STORE: begin
        if (issuing) issue_d = issue_q + 3'd1;
        if (last_issue) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q   <= ST_IDLE;
      op_q      <= LSU_NONE;
      rd_we_q   <= 1'b0;
      rd_q      <= '0;
      base_q    <= '0;
      sdata_q   <= '0;
      issue_q   <= 3'd0;
      cap_q     <= 3'd0;
      bytes_q   <= ZERO_WORD;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_we_q   <= rd_we_d;
      rd_q      <= rd_d;
      base_q    <= base_d;
      sdata_q   <= sdata_d;
      issue_q   <= issue_d;
      cap_q     <= cap_d;
      bytes_q   <= bytes_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // RAM port is quiet during reset so an aborted store writes nothing more.
  assign mem_wr    = !in_reset && (state_q == ST_STORE) && issuing;
  assign mem_a     = (!in_reset && issuing) ? base_q + ADDR_W'(issue_q) : '0;
  assign mem_dout  = mem_wr ? sdata_q[{issue_q[1:0], 3'b000} +: 8] : 8'h00;
  assign stall_req = !in_reset && (accept_mem ||
                                   ((state_q == ST_LOAD) && !last_cap) ||
                                   ((state_q == ST_STORE) && !last_issue));

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// tb_mem_lsu : scoreboard bench for mem_lsu with a byte-array reference model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_op;
  logic        in_rd_we;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic [31:0] in_sdata;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        stall_req;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op),
    .in_rd_we(in_rd_we), .in_rd(in_rd), .in_alu(in_alu), .in_sdata(in_sdata),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .stall_req(stall_req), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct { logic [31:0] a; logic [7:0] d; int c; } mem_ev_t;
  typedef struct { logic [4:0] r; logic [31:0] d; int c; } wb_ev_t;

  mem_ev_t exp_wr[$];
  mem_ev_t exp_rd[$];
  wb_ev_t  exp_wb[$];

  logic [7:0] env_ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    if (env_ram.exists(a)) return env_ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  // Synchronous byte RAM seen by the DUT.
  always @(posedge clk) begin
    if (mem_wr) env_ram[mem_a] = mem_dout;
    mem_din <= env_rd(mem_a);
  end

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: expected RAM traffic, write-back and stall length per instruction.
  task automatic model(input logic [3:0] op, input logic we, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd, input int a,
                       output int exp_stall);
    int n;
    logic [31:0] v;
    logic [31:0] addr;
    mem_ev_t ev;
    wb_ev_t wev;
    case (op)
      4'd1, 4'd4, 4'd6: n = 1;
      4'd2, 4'd5, 4'd7: n = 2;
      4'd3, 4'd8:       n = 4;
      default:          n = 0;
    endcase
    if (op >= 4'd6 && op <= 4'd8) begin
      for (int k = 0; k < n; k++) begin
        addr = alu + 32'(k);
        ev = '{a: addr, d: 8'(sd >> (8 * k)), c: a + 1 + k};
        exp_wr.push_back(ev);
        ref_mem[addr] = ev.d;
      end
      exp_stall = n;
    end else if (op >= 4'd1 && op <= 4'd5) begin
      v = 32'h0;
      for (int k = 0; k < n; k++) begin
        addr = alu + 32'(k);
        ev = '{a: addr, d: 8'h00, c: a + 1 + k};
        exp_rd.push_back(ev);
        v = v | (32'(ref_rd(addr)) << (8 * k));
      end
      if (op == 4'd1 && v >= 32'h80)   v = v + 32'hFFFFFF00;
      if (op == 4'd2 && v >= 32'h8000) v = v + 32'hFFFF0000;
      if (we && rd != 5'd0) begin
        wev = '{r: rd, d: v, c: a + n + 2};
        exp_wb.push_back(wev);
      end
      exp_stall = n + 1;
    end else begin
      if (we && rd != 5'd0) begin
        wev = '{r: rd, d: alu, c: a + 1};
        exp_wb.push_back(wev);
      end
      exp_stall = 0;
    end
  endtask

  // Monitor: compares every RAM access and every write-back against the queues.
  initial begin
    mem_ev_t e;
    wb_ev_t w;
    forever begin
      @(posedge clk);
      #2;
      while (exp_wr.size() > 0 && exp_wr[0].c < cyc) begin
        e = exp_wr.pop_front();
        chk("write_missing", 1'b0, 64'(cyc), 64'(e.c));
      end
      if (mem_wr) begin
        if (exp_wr.size() == 0) chk("write_unexpected", 1'b0, 64'(mem_a), 64'h0);
        else begin
          e = exp_wr.pop_front();
          chk("write", mem_a == e.a && mem_dout == e.d && cyc == e.c,
              {mem_a, 24'h0, mem_dout}, {e.a, 24'h0, e.d});
        end
      end
      while (exp_rd.size() > 0 && exp_rd[0].c < cyc) begin
        e = exp_rd.pop_front();
        chk("read_missing", 1'b0, 64'(cyc), 64'(e.c));
      end
      if (exp_rd.size() > 0 && exp_rd[0].c == cyc) begin
        e = exp_rd.pop_front();
        chk("read_addr", mem_a == e.a && !mem_wr, {31'h0, mem_wr, mem_a}, {32'h0, e.a});
      end
      while (exp_wb.size() > 0 && exp_wb[0].c < cyc) begin
        w = exp_wb.pop_front();
        chk("wb_missing", 1'b0, 64'(cyc), 64'(w.c));
      end
      if (wb_we === 1'b1) begin
        if (exp_wb.size() == 0) chk("wb_unexpected", 1'b0, {27'h0, wb_addr, wb_data}, 64'h0);
        else begin
          w = exp_wb.pop_front();
          chk("wb", wb_addr == w.r && wb_data == w.d && cyc == w.c,
              {27'h0, wb_addr, wb_data}, {27'h0, w.r, w.d});
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic we, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd);
    int a, exp_st, st;
    bit done;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd_we = we; in_rd = rd; in_alu = alu; in_sdata = sd;
    a = cyc;
    model(op, we, rd, alu, sd, a, exp_st);
    st = 0;
    done = 1'b0;
    for (int t = 0; t < 16 && !done; t++) begin
      #1;
      if (stall_req) begin
        st++;
        @(negedge clk);
        // The held instruction must be ignored once accepted.
        in_alu = $urandom; in_sdata = $urandom; in_rd = 5'($urandom);
      end else done = 1'b1;
    end
    chk("stall_cycles", done && st == exp_st, 64'(st), 64'(exp_st));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_op = 4'($urandom); in_rd_we = 1'b1;
      in_rd = 5'($urandom); in_alu = $urandom;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int a;
    mem_ev_t ev;
    rst = 1'b1; in_valid = 1'b1; in_op = 4'd8; in_rd_we = 1'b1; in_rd = 5'd7;
    in_alu = 32'h40; in_sdata = 32'h11223344;
    env_ram[32'h200] = 8'h80; env_ram[32'h201] = 8'h7F;
    ref_mem[32'h200] = 8'h80; ref_mem[32'h201] = 8'h7F;

    // Reset held three cycles with a store presented.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_stall", stall_req == 1'b0, 64'(stall_req), 64'h0);
      chk("rst_mem_wr", mem_wr == 1'b0, 64'(mem_wr), 64'h0);
      chk("rst_wb", wb_we == 1'b0 && wb_addr == 5'd0 && wb_data == 32'h0,
          {27'h0, wb_addr, wb_data}, 64'h0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("post_rst_idle", mem_wr == 1'b0 && stall_req == 1'b0 && mem_a == 32'h0,
        {31'h0, mem_wr, mem_a}, 64'h0);

    // Directed cases.
    issue(4'd0, 1'b1, 5'd5, 32'h12345678, 32'h0);
    issue(4'd0, 1'b1, 5'd0, 32'h9ABCDEF0, 32'h0);
    issue(4'd8, 1'b1, 5'd4, 32'h100, 32'hAABBCCDD);
    issue(4'd2, 1'b1, 5'd3, 32'h200, 32'h0);
    issue(4'd1, 1'b1, 5'd3, 32'h200, 32'h0);
    issue(4'd4, 1'b1, 5'd3, 32'h200, 32'h0);
    issue(4'd3, 1'b1, 5'd9, 32'h200, 32'h0);
    issue(4'd3, 1'b1, 5'd10, 32'hFFFFFFFE, 32'h0);
    issue(4'd3, 1'b1, 5'd0, 32'h100, 32'h0);
    issue(4'd3, 1'b1, 5'd11, 32'h100, 32'h0);
    issue(4'd6, 1'b0, 5'd0, 32'h205, 32'h000000E7);
    issue(4'd13, 1'b1, 5'd12, 32'hCAFEF00D, 32'h0);
    idle(2);

    // Reset during the second byte of a word store aborts it.
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd8; in_rd_we = 1'b1; in_rd = 5'd6;
    in_alu = 32'h300; in_sdata = 32'h01020304;
    a = cyc;
    ev = '{a: 32'h300, d: 8'h04, c: a + 1};
    exp_wr.push_back(ev);
    ref_mem[32'h300] = 8'h04;
    #1;
    chk("abort_accept_stall", stall_req == 1'b1, 64'(stall_req), 64'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_idle", stall_req == 1'b0 && mem_wr == 1'b0 && wb_we == 1'b0,
        {61'h0, stall_req, mem_wr, wb_we}, 64'h0);
    idle(1);

    // Randomized mix over a small window so loads observe earlier stores.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else addr = 32'h200 + 32'($urandom_range(0, 39));
      issue(4'($urandom_range(0, 15)), 1'($urandom), 5'($urandom), addr, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(12);
    chk("drain_wr", exp_wr.size() == 0, 64'(exp_wr.size()), 64'h0);
    chk("drain_rd", exp_rd.size() == 0, 64'(exp_rd.size()), 64'h0);
    chk("drain_wb", exp_wb.size() == 0, 64'(exp_wb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit between ex_mem and mem_wb.
- Performs byte-serial accesses on the 8-bit synchronous RAM port.
- Assembles and sign/zero-extends load data, and stalls the pipeline while busy.
- Produces the write-back triple (wb_we, wb_addr, wb_data) that mem_wb forwards to the register-file write port.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, register/data width (must equal the register width)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ex_mem holds a valid instruction this cycle
- in_op  in  4  LSU op: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW (codes in config.vh)
- in_rd_we  in  1  instruction writes rd
- in_rd  in  5  destination register
- in_alu  in  DATA_W  ALU result (effective address for mem ops, rd data for NONE)
- in_sdata  in  DATA_W  store data (rs2)
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- mem_dout  out  8  store byte
- mem_din  in  8  read byte; valid the cycle after its address is issued
- stall_req  out  1  freeze IF..EX/ex_mem this cycle
- wb_we  out  1  registered write enable to mem_wb
- wb_addr  out  5  registered rd
- wb_data  out  DATA_W  registered write data

Behaviour:
- States: IDLE, LOAD, STORE.
- Byte count N: 1 for B/BU, 2 for H/HU, 4 for W.
- Little-endian; byte k uses address in_alu+k, 32-bit wrap-around (0xFFFFFFFF+1 = 0).
- Reset:
  - state=IDLE; wb_we=0, wb_addr=0, wb_data=0.
  - mem_wr=0, mem_a=0, mem_dout=0; stall_req=0.
  - Counters cleared.
  - Reset mid-access aborts the access: no further RAM write, no wb pulse.
- IDLE, in_valid=0: wb_we<=0 next cycle.
- IDLE, in_valid, op NONE:
  - Next cycle wb_we=in_rd_we&&(in_rd!=0), wb_addr=in_rd, wb_data=in_alu.
  - Latency 1, no stall.
- IDLE, in_valid, mem op (accept cycle A):
  - stall_req=1 combinationally.
  - Latch base address, rd, op, store data.
  - Go to LOAD or STORE; issue counter and capture counter = 0.
  - wb_we<=0 next cycle.
- LOAD:
  - Cycle A+1+k (k<N): mem_a=base+k, mem_wr=0.
  - mem_din captured into byte k at the end of cycle A+2+k.
  - stall_req=1 through cycle A+N; stall_req=0 in cycle A+N+1, when the last byte is captured.
  - At the end of cycle A+N+1:
    - wb_we=rd_we&&(rd!=0), wb_addr=rd.
    - wb_data = extended value: LB/LH sign-extend, LBU/LHU zero-extend.
    - state=IDLE.
  - Total stall N+1 cycles; wb valid at A+N+2.
- STORE:
  - Cycle A+1+k: mem_a=base+k, mem_wr=1, mem_dout=sdata[8k+7:8k].
  - stall_req=1 through A+N-1; stall_req=0 at A+N, the last write cycle.
  - Then IDLE; wb_we=0 at A+N+1.
- Inputs seen while state!=IDLE (the held instruction) are ignored.
- Outside LOAD/STORE issue cycles: mem_wr=0, mem_a=0.
- in_rd=0: wb_we forced 0, including loads; the RAM read still occurs.
- Back-to-back mem ops: the second is accepted in the cycle after return to IDLE. No idle cycle inserted beyond that.
- Unused op codes are treated as NONE.

Decomposition:
- config.vh holds:
  - LSU op encodings (LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW)
  - RegAddrLen, RegLen, ZERO_WORD
  - ResetEnable, WriteEnable
  - State encodings
- One combinational sub-module, lsu_extend: inputs op and 32-bit assembled bytes, output extended word.
- FSM, counters and wb registers stay in mem_lsu.

Test Plan:
- Reset held 3 cycles while in_valid=1, op=SW -> wb_we=0, mem_wr=0, stall_req=0 throughout; first post-reset cycle still IDLE.
- op NONE, rd=5, alu=0x1234_5678 -> next cycle wb_we=1, wb_addr=5, wb_data=0x12345678; stall_req never high. Same with rd=0 -> wb_we=0.
- SW addr 0x100, sdata 0xAABBCCDD -> writes DD@0x100, CC@0x101, BB@0x102, AA@0x103 on A+1..A+4; stall_req high A..A+3, low A+4; wb_we=0.
- Model RAM holding 0x80,0x7F at 0x200/0x201:
  - LH 0x200, rd=3 -> wb_data=0xFFFF_7F80? No: LH assembles 0x7F80 -> wb_data=0x00007F80.
  - LB 0x200 -> 0xFFFFFF80.
  - LBU 0x200 -> 0x00000080.
  - LW latency: stall high 5 cycles, wb at A+6.
- LW at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 issued in order.
- Reset asserted at A+2 of SW -> exactly 1 byte written (A+1), then mem_wr=0, state IDLE, wb_we=0.
- LW followed immediately by SB -> SB accepted the cycle after LW's last capture; no lost or duplicate accesses.
